uart_arbiter: RTL

- Two-master arbiter that shares one uart peripheral port (valid/instr/addr/wdata/wstrb/rdata/ready) between requesters, e.g. the core data port and a debug/loader master.
- Captures one-cycle request pulses, grants round-robin, and issues exactly one uart_valid pulse per transaction.
- Holds ownership until uart_ready, then routes rdata/ready back to the owner only.
- Sits between the bus decode and the uart block.

---
 rtl/uart_arbiter_if.sv | 54 +++++
 rtl/uart_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_arbiter_if.sv
// uart_arbiter_if: bundles the two requester ports and the shared uart port.
//   m0_* / m1_*  : requester side (valid pulse, instr, addr, wdata, wstrb in;
//                  rdata, ready back)
//   uart_*       : peripheral side (valid pulse and registered request out;
//                  rdata, ready in)
//   arb_error    : one-cycle timeout indication toward the requesters
// Modports: slave = the arbiter, master = requesters plus uart peripheral.
interface uart_arbiter_if;
  logic        m0_valid;
  logic        m0_instr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_rdata;
  logic        m0_ready;

  logic        m1_valid;
  logic        m1_instr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_rdata;
  logic        m1_ready;

  logic        uart_valid;
  logic        uart_instr;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic [3:0]  uart_wstrb;
  logic [31:0] uart_rdata;
  logic        uart_ready;

  logic        arb_error;

  modport slave (
    input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
    output m0_rdata, m0_ready,
    input  m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
    output m1_rdata, m1_ready,
    output uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
    input  uart_rdata, uart_ready,
    output arb_error
  );

  modport master (
    output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
    input  m0_rdata, m0_ready,
    output m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
    input  m1_rdata, m1_ready,
    input  uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
    output uart_rdata, uart_ready,
    input  arb_error
  );
endinterface

// File: rtl/uart_arbiter.sv
// uart_arbiter: shares one uart port between two requesters.
//   Each requester's one-cycle valid pulse is captured into a one-deep slot
//   (a newer pulse overwrites it). In IDLE a round-robin grant picks a
//   requester, the payload is registered onto uart_*, uart_valid pulses for
//   one cycle (ISSUE), then BUSY waits for uart_ready, which is routed
//   combinationally to the owner only.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - uart_arbiter_if.slave (m0_*, m1_*, uart_*, arb_error)
// Build option: define UART_ARB_TIMEOUT_EN to enable the BUSY wait counter;
//   after TIMEOUT_CYCLES BUSY cycles without uart_ready the owner receives
//   ready with rdata=32'hFFFFFFFF and arb_error pulses. Without it BUSY waits
//   indefinitely and arb_error is tied 0.
module uart_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic           clk,
  input logic           rst,
  uart_arbiter_if.slave bus
);
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  // The timeout compares against TIMEOUT_CYCLES-1, so anything below 2
  // would fire on the first BUSY cycle or wrap.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_t     state;
  logic [1:0] pending;
  req_t [1:0] slot;
  logic       owner;
  logic       last_grant;
  req_t       uart_req;
  logic       uart_valid_q;

  logic [1:0] live_vld;
  req_t [1:0] live_req;

  assign live_vld    = {bus.m1_valid, bus.m0_valid};
  assign live_req[0] = {bus.m0_instr, bus.m0_addr, bus.m0_wdata, bus.m0_wstrb};
  assign live_req[1] = {bus.m1_instr, bus.m1_addr, bus.m1_wdata, bus.m1_wstrb};

  // Same-cycle valids take part in the grant; a live payload is newer than
  // whatever sits in that master's slot.
  logic [1:0] want;
  logic       grant_any;
  logic       grant_id;
  req_t       grant_req;

  always_comb begin
    want      = pending | live_vld;
    grant_any = |want;
    grant_id  = (&want) ? ~last_grant : want[1];
    grant_req = live_vld[grant_id] ? live_req[grant_id] : slot[grant_id];
  end

  // Completion is only honoured in BUSY; a stray uart_ready elsewhere is dropped.
  logic        done_ok;
  logic        done_to;
  logic [31:0] resp_data;

  assign done_ok = (state == BUSY) && bus.uart_ready;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;
  assign done_to = (state == BUSY) && !bus.uart_ready &&
                   (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign done_to = 1'b0;
`endif

  assign resp_data = done_to ? 32'hFFFF_FFFF : bus.uart_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      slot         <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      uart_req     <= '0;
      uart_valid_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (live_vld[i]) begin
          pending[i] <= 1'b1;
          slot[i]    <= live_req[i];
        end
      end
      uart_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            // Later NBA wins over the capture above: the granted request,
            // live or held, is consumed here.
            pending[grant_id] <= 1'b0;
            owner             <= grant_id;
            last_grant        <= grant_id;
            uart_req          <= grant_req;
            uart_valid_q      <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          state <= BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        BUSY: begin
          if (done_ok || done_to) state <= IDLE;
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + 32'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uart_valid = uart_valid_q;
  assign bus.uart_instr = uart_req.instr;
  assign bus.uart_addr  = uart_req.addr;
  assign bus.uart_wdata = uart_req.wdata;
  assign bus.uart_wstrb = uart_req.wstrb;

  assign bus.m0_ready = (done_ok || done_to) && (owner == 1'b0);
  assign bus.m1_ready = (done_ok || done_to) && (owner == 1'b1);
  assign bus.m0_rdata = bus.m0_ready ? resp_data : 32'h0;
  assign bus.m1_rdata = bus.m1_ready ? resp_data : 32'h0;
  assign bus.arb_error = done_to;
endmodule
